// File: rtl/alu_issue_unit_if.sv
// rtl/alu_issue_unit_if.sv - command, result and ALU-side signal bundle for alu_issue_unit
interface alu_issue_unit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [4:0]       in_op;
    logic             in_cin;
    logic             in_use_acc;
    logic             in_use_carry;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
    logic             out_zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_mode;
    logic [3:0]       alu_sel;
    logic             alu_cin_n;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout_n;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, in_use_acc, in_use_carry,
        output in_ready,
        output out_valid, out_result, out_cout, out_zero,
        input  out_ready,
        output alu_a, alu_b, alu_mode, alu_sel, alu_cin_n,
        input  alu_result, alu_cout_n
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, in_use_acc, in_use_carry,
        input  in_ready,
        input  out_valid, out_result, out_cout, out_zero,
        output out_ready,
        input  alu_a, alu_b, alu_mode, alu_sel, alu_cin_n,
        output alu_result, alu_cout_n
    );
endinterface

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - registered issue/capture front-end for the 16-bit 74181 ALU
module alu_issue_unit #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [3:0]       sel_q, sel_d;
    logic             cin_n_q, cin_n_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        res_d   = res_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        cin_n_d = cin_n_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_use_acc ? acc_q : bus.in_a;
                    b_d     = bus.in_b;
                    mode_d  = bus.in_op[4];
                    sel_d   = bus.in_op[3:0];
                    // ALU carry pins are active-low; the unit works active-high
                    cin_n_d = ~(bus.in_use_carry ? carry_q : bus.in_cin);
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    res_d   = bus.alu_result;
                    cout_d  = ~bus.alu_cout_n;
                    zero_d  = (bus.alu_result == '0);
                    acc_d   = bus.alu_result;
                    carry_d = ~bus.alu_cout_n;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            sel_q   <= '0;
            cin_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            cin_n_q <= cin_n_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = valid_q;
    assign bus.out_result = res_q;
    assign bus.out_cout   = cout_q;
    assign bus.out_zero   = zero_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_mode   = mode_q;
    assign bus.alu_sel    = sel_q;
    assign bus.alu_cin_n  = cin_n_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - scoreboard bench for alu_issue_unit with a behavioural ALU
module tb_alu_issue_unit;
    localparam int W = 16;
    localparam logic [4:0] ADD_OP = 5'b0_1001;
    localparam logic [4:0] SUB_OP = 5'b0_0110;
    localparam logic [4:0] XOR_OP = 5'b1_0110;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_unit_if #(.WIDTH(W)) bus();

    alu_issue_unit #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t         sb[$];
    logic [W-1:0] m_acc;
    logic         m_carry;
    int           n_checks = 0;
    int           n_pass   = 0;

    // returns {carry_out_active_high, result}
    function automatic logic [W:0] alu_fn(input logic [4:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
        case (op)
            ADD_OP:  return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            SUB_OP:  return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
            XOR_OP:  return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    logic [W:0] alu_sum;
    always_comb begin
        alu_sum        = alu_fn({bus.alu_mode, bus.alu_sel}, bus.alu_a, bus.alu_b, ~bus.alu_cin_n);
        bus.alu_result = alu_sum[W-1:0];
        bus.alu_cout_n = ~alu_sum[W];
    end

    task automatic drive_cmd(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic ua, input logic uc,
                             input bit keep_valid, output bit ok);
        logic       rdy;
        logic [W:0] s;
        ok = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_op        = op;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_cin       = cin;
        bus.in_use_acc   = ua;
        bus.in_use_carry = uc;
        for (int i = 0; i < 100 && !ok; i++) begin
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) begin
                s = alu_fn(op, ua ? m_acc : a, b, uc ? m_carry : cin);
                sb.push_back('{r: s[W-1:0], c: s[W], z: (s[W-1:0] == '0)});
                m_acc   = s[W-1:0];
                m_carry = s[W];
                ok = 1'b1;
            end
            @(negedge clk);
        end
        if (!keep_valid) bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
        bus.in_cin = 1'b0; bus.in_use_acc = 1'b0; bus.in_use_carry = 1'b0;
        bus.out_ready = 1'b0;
        m_acc = '0; m_carry = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL reset_handshake ready=%b valid=%b want ready=1 valid=0", bus.in_ready, bus.out_valid);
        else n_pass++;
        n_checks++;
        if ({bus.out_result, bus.out_cout, bus.out_zero} !== {{W{1'b0}}, 2'b00})
            $display("FAIL reset_out got %h/%b/%b want 0/0/0", bus.out_result, bus.out_cout, bus.out_zero);
        else n_pass++;
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_sel, bus.alu_cin_n} !== {{W{1'b0}}, {W{1'b0}}, 5'b0, 1'b1})
            $display("FAIL reset_alu a=%h b=%h m=%b s=%h cin_n=%b want 0,0,0,0,1",
                     bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_sel, bus.alu_cin_n);
        else n_pass++;
    endtask

    task automatic test_add_latency();
        bit ok; int lat; exp_t e;
        drive_cmd(ADD_OP, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        n_checks++;
        if (!ok) $display("FAIL add_accept timeout"); else n_pass++;
        n_checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_cin_n} !== {16'h00FF, 16'h0001, 1'b1})
            $display("FAIL add_alu_drive a=%h b=%h cin_n=%b want 00ff 0001 1", bus.alu_a, bus.alu_b, bus.alu_cin_n);
        else n_pass++;
        wait_valid(ok, lat);
        n_checks++;
        if (!ok || lat != 3) $display("FAIL add_latency got %0d want 3 (seen=%0b)", lat, ok); else n_pass++;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if ({bus.out_result, bus.out_cout, bus.out_zero} !== {e.r, e.c, e.z})
            $display("FAIL add_result got %h/%b/%b want %h/%b/%b", bus.out_result, bus.out_cout, bus.out_zero, e.r, e.c, e.z);
        else n_pass++;
        drain();
    endtask

    task automatic test_chain();
        bit ok; int lat; exp_t e;
        drive_cmd(ADD_OP, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        wait_valid(ok, lat);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (!ok || {bus.out_result, bus.out_cout, bus.out_zero} !== {e.r, e.c, e.z})
            $display("FAIL chain_wrap got %h/%b/%b want %h/%b/%b", bus.out_result, bus.out_cout, bus.out_zero, e.r, e.c, e.z);
        else n_pass++;
        drain();
        drive_cmd(ADD_OP, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, ok);
        n_checks++;
        if ({bus.alu_a, bus.alu_cin_n} !== {16'h0000, 1'b0})
            $display("FAIL chain_drive a=%h cin_n=%b want 0000 0", bus.alu_a, bus.alu_cin_n);
        else n_pass++;
        wait_valid(ok, lat);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (!ok || {bus.out_result, bus.out_cout, bus.out_zero} !== {e.r, e.c, e.z})
            $display("FAIL chain_acc got %h/%b/%b want %h/%b/%b", bus.out_result, bus.out_cout, bus.out_zero, e.r, e.c, e.z);
        else n_pass++;
        drain();
    endtask

    task automatic test_logic_sub();
        bit ok; int lat; exp_t e;
        drive_cmd(XOR_OP, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        wait_valid(ok, lat);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (!ok || {bus.out_result, bus.out_zero} !== {e.r, e.z})
            $display("FAIL xor_result got %h/%b want %h/%b", bus.out_result, bus.out_zero, e.r, e.z);
        else n_pass++;
        drain();
        drive_cmd(SUB_OP, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, ok);
        wait_valid(ok, lat);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (!ok || {bus.out_result, bus.out_cout, bus.out_zero} !== {e.r, e.c, e.z})
            $display("FAIL sub_result got %h/%b/%b want %h/%b/%b", bus.out_result, bus.out_cout, bus.out_zero, e.r, e.c, e.z);
        else n_pass++;
        drain();
    endtask

    task automatic test_backpressure();
        bit ok; int lat; exp_t e;
        drive_cmd(ADD_OP, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        wait_valid(ok, lat);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bus.out_valid, bus.out_result, bus.out_cout, bus.out_zero, bus.in_ready} !== {1'b1, e.r, e.c, e.z, 1'b0})
                $display("FAIL bp_hold cyc%0d got v=%b %h/%b/%b rdy=%b want v=1 %h/%b/%b rdy=0", i,
                         bus.out_valid, bus.out_result, bus.out_cout, bus.out_zero, bus.in_ready, e.r, e.c, e.z);
            else n_pass++;
            bus.in_valid = (i % 2 == 0);
            bus.in_op    = XOR_OP;
            bus.in_a     = 16'hDEAD;
            bus.in_b     = 16'hBEEF;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        drain();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
        else n_pass++;
        drive_cmd(ADD_OP, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, ok);
        wait_valid(ok, lat);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (!ok || bus.out_result !== e.r)
            $display("FAIL bp_ignored_cmd got %h want %h", bus.out_result, e.r);
        else n_pass++;
        drain();
    endtask

    task automatic test_reset_midflight();
        bit ok; int lat; exp_t e; bit seen;
        drive_cmd(ADD_OP, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, ok);
        void'(sb.pop_back());
        m_acc = '0; m_carry = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({bus.alu_cin_n, bus.alu_a, bus.in_ready, bus.out_valid} !== {1'b1, 16'h0000, 1'b1, 1'b0})
            $display("FAIL rst_mid cin_n=%b a=%h rdy=%b v=%b want 1 0000 1 0",
                     bus.alu_cin_n, bus.alu_a, bus.in_ready, bus.out_valid);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen) $display("FAIL rst_discard got valid=1 want 0"); else n_pass++;
        drive_cmd(ADD_OP, 16'h0000, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, ok);
        wait_valid(ok, lat);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_checks++;
        if (!ok || bus.out_result !== e.r)
            $display("FAIL rst_acc_cleared got %h want %h", bus.out_result, e.r);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int acc_ok = 0;
        fork
            begin
                bit ok;
                for (int k = 0; k < 4; k++) begin
                    drive_cmd(ADD_OP, 16'(k * 16'h1111 + 1), 16'(k * 16'h0100 + 3), (k % 2 == 1),
                              1'b0, 1'b0, 1'b1, ok);
                    if (ok) acc_ok++;
                end
                bus.in_valid = 1'b0;
            end
            begin
                exp_t e;
                bus.out_ready = 1'b1;
                for (int c = 0; c < 200 && got < 4; c++) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        n_checks++;
                        if (sb.size() == 0) begin
                            $display("FAIL b2b_extra got %h want none", bus.out_result);
                        end else begin
                            e = sb.pop_front();
                            if ({bus.out_result, bus.out_cout, bus.out_zero} !== {e.r, e.c, e.z})
                                $display("FAIL b2b_result%0d got %h/%b/%b want %h/%b/%b", got,
                                         bus.out_result, bus.out_cout, bus.out_zero, e.r, e.c, e.z);
                            else n_pass++;
                        end
                        got++;
                    end
                end
                @(negedge clk);
                bus.out_ready = 1'b0;
            end
        join
        n_checks++;
        if (got != 4 || acc_ok != 4 || sb.size() != 0)
            $display("FAIL b2b_count got=%0d accepted=%0d left=%0d want 4 4 0", got, acc_ok, sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_chain();
        test_logic_sub();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequential front-end for the combinational 16-bit ALU (top_alu_16, 74181/74182 carry-lookahead). Sits directly upstream of it and also captures what it produces.
- Accepts operation commands over a valid/ready handshake and drives registered operands, mode and sel into the ALU.
- Waits a fixed settle time for ripple/lookahead propagation, then captures result, carry and zero into an output register with its own valid/ready handshake.
- Converts between the unit's active-high carry convention and the ALU's active-low Cin/Cout. Supports chaining through an internal accumulator and carry register.

Parameters:
- WIDTH, 16, operand/result width; must match ALU width.
- SETTLE_CYCLES, 2, cycles between driving ALU inputs and capturing outputs; legal range 1..15.

Ports:
- clk  input  1  clock; all registers update on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  command valid.
- in_ready  output  1  unit can accept a command.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  5  {mode, sel[3:0]}; encodings as in opcodes.vh (ADD_OP, SUB_OP, XOR_OP, ...).
- in_cin  input  1  carry in, active-high.
- in_use_acc  input  1  replace in_a with the accumulator.
- in_use_carry  input  1  replace in_cin with the stored carry.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  captured ALU result.
- out_cout  output  1  captured carry out, active-high (= ~Cout pin, no per-op adjustment).
- out_zero  output  1  out_result == 0.
- alu_a  output  WIDTH  to ALU a.
- alu_b  output  WIDTH  to ALU b.
- alu_mode  output  1  to ALU mode (= op[4]).
- alu_sel  output  4  to ALU sel (= op[3:0]).
- alu_cin_n  output  1  to ALU Cin, active-low.
- alu_result  input  WIDTH  from ALU result.
- alu_cout_n  input  1  from ALU Cout, active-low.

Behaviour:
- FSM states: IDLE, SETTLE, HOLD.
- in_ready = (state == IDLE). It is combinational from the state register, so it reads 1 in the first cycle after reset releases.
- IDLE, in_valid=1 at edge T0 (accept):
  - Register alu_a = in_use_acc ? acc : in_a; alu_b = in_b; alu_mode/alu_sel = in_op; alu_cin_n = ~(in_use_carry ? carry_reg : in_cin).
  - Load cnt = SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - If cnt == 0 at an edge, capture out_result = alu_result, out_cout = ~alu_cout_n, out_zero = (alu_result == 0); acc = alu_result; carry_reg = ~alu_cout_n. Set out_valid=1 and go to HOLD.
  - Otherwise decrement cnt.
- Latency: capture at edge T0+SETTLE_CYCLES. out_valid is high from the cycle after that edge (default: 3rd cycle after the accept cycle).
- HOLD:
  - out_valid=1 and all out_* stable until out_ready=1 at an edge. Then out_valid=0 and go to IDLE.
  - in_ready=0 throughout HOLD; no overlap. Next accept is at the earliest one edge after the drain.
- ALU-facing registers keep their values outside SETTLE; inputs are not re-driven until the next accept.
- in_valid while not IDLE is ignored. Command signals need not be stable after acceptance.
- acc and carry_reg update only at capture. in_use_acc/in_use_carry read values from the most recent completed operation.
- Reset (rst_n=0 at an edge, in any state including mid-SETTLE or HOLD):
  - state=IDLE, cnt=0, out_valid=0, out_result=0, out_cout=0, out_zero=0 (flag register cleared, not recomputed).
  - acc=0, carry_reg=0, alu_a=0, alu_b=0, alu_mode=0, alu_sel=0, alu_cin_n=1.
  - An in-flight operation is discarded, never emitted.
- Logic ops (mode=1): result captured identically; out_cout is the raw inverted pin and carries no meaning.
- SUB: out_cout follows ALU pin semantics (1 = no borrow).

Test Plan:
- ADD_OP, a=0x00FF, b=0x0001, cin=0, SETTLE_CYCLES=2 -> out_result=0x0100, out_cout=0, out_zero=0. out_valid is first high exactly 3 cycles after the accept cycle; alu_cin_n=1 while settling.
- ADD_OP, a=0xFFFF, b=0x0001, cin=0 -> 0x0000, cout=1, zero=1. Then ADD_OP with use_acc=1, use_carry=1, a=0x1234 (ignored), b=0x0000 -> 0x0001, cout=0, zero=0.
- XOR_OP a=0xAAAA b=0x5555 -> 0xFFFF. SUB_OP a=0x1234 b=0x1234 cin=1 -> 0x0000, zero=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid, out_result, out_cout, out_zero constant and in_ready=0 throughout; in_valid pulses are ignored. Raise out_ready -> out_valid=0 next cycle, in_ready=1.
- Reset: assert rst_n=0 for one edge during SETTLE of ADD 0x0001+0x0001 -> out_valid never rises for it, alu_cin_n=1, alu_a=0, in_ready=1. A following use_acc ADD with b=0x0005 -> 0x0005.
- Back-to-back: 4 ADD_OP commands with in_valid held high and out_ready=1 -> each accepted only in IDLE; results emitted in order with no loss or duplication.
